// File: rtl/spi_cfg_controller.sv
// SPI write-frame sequencer: buffers (addr, data) requests in a FIFO and sends each
// as a 16-bit mode-0 frame {1'b1, addr, data}, MSB first, with registered SPI outputs.
module spi_cfg_controller #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI,
  output logic [7:0] frames_sent
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] sh_q, sh_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  frames_q, frames_d;
  logic        sclk_q, sclk_d;
  logic        ncs_q, ncs_d;
  logic        copi_q, copi_d;

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [15:0]  mem_q [FIFO_DEPTH];
  logic         fifo_empty, fifo_full;
  logic         push, pop;
  logic [15:0]  rd_word;
  logic         in_frame;

  // Full when the index bits match but the wrap bits differ.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = req_valid && !fifo_full;
  assign rd_word    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {1'b1, req_addr, req_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = (div_q == 8'd0) ? 8'd0 : div_q - 8'd1;
    sh_d     = sh_q;
    bit_d    = bit_q;
    frames_d = frames_q;
    pop      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = rd_word;
          bit_d   = '0;
          div_d   = DIV_RELOAD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_q == 8'd0) begin
          div_d   = DIV_RELOAD;
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (div_q == 8'd0) begin
          div_d = DIV_RELOAD;
          if (bit_q == 4'd15) begin
            state_d = HOLD;
          end else begin
            // Next bit is presented on the SCLK falling edge.
            sh_d    = {sh_q[14:0], 1'b0};
            state_d = SHIFT_LO;
          end
        end
      end
      SHIFT_LO: begin
        if (div_q == 8'd0) begin
          bit_d   = bit_q + 4'd1;
          div_d   = DIV_RELOAD;
          state_d = SHIFT_HI;
        end
      end
      HOLD: begin
        if (div_q == 8'd0) begin
          frames_d = frames_q + 8'd1;
          div_d    = GAP_RELOAD;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (div_q == 8'd0) begin
          div_d = DIV_RELOAD;
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = rd_word;
            bit_d   = '0;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // SPI pins are decoded from the next state so they leave the flops glitch-free.
    in_frame = (state_d == SETUP) || (state_d == SHIFT_HI) ||
               (state_d == SHIFT_LO) || (state_d == HOLD);
    sclk_d   = (state_d == SHIFT_HI);
    ncs_d    = !in_frame;
    copi_d   = in_frame ? sh_d[15] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      sh_q     <= '0;
      bit_q    <= '0;
      frames_q <= '0;
      sclk_q   <= 1'b0;
      ncs_q    <= 1'b1;
      copi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      frames_q <= frames_d;
      sclk_q   <= sclk_d;
      ncs_q    <= ncs_d;
      copi_q   <= copi_d;
    end
  end

  assign req_ready   = !fifo_full;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign SCLK        = sclk_q;
  assign nCS         = ncs_q;
  assign COPI        = copi_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Scoreboard bench for spi_cfg_controller: stimulus queues expected frames, a negedge
// monitor reassembles SPI frames and checks word, SCLK rise count, nCS low and gap times.
module tb_spi_cfg_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       busy, SCLK, nCS, COPI;
  logic [7:0] frames_sent;

  logic       rst_w = 1'b1;
  logic       req_valid_w = 1'b0;
  logic       req_ready_w;
  logic [6:0] req_addr_w = '0;
  logic [7:0] req_data_w = '0;
  logic       busy_w, sclk_w, ncs_w, copi_w;
  logic [7:0] frames_sent_w;

  spi_cfg_controller #(.CLK_DIV(4), .FIFO_DEPTH(4), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .busy(busy), .SCLK(SCLK),
    .nCS(nCS), .COPI(COPI), .frames_sent(frames_sent)
  );

  spi_cfg_controller #(.CLK_DIV(1), .FIFO_DEPTH(4), .GAP_CYCLES(1)) dut_w (
    .clk(clk), .rst(rst_w), .req_valid(req_valid_w), .req_ready(req_ready_w),
    .req_addr(req_addr_w), .req_data(req_data_w), .busy(busy_w), .SCLK(sclk_w),
    .nCS(ncs_w), .COPI(copi_w), .frames_sent(frames_sent_w)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] word;
    bit          chk_gap;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: frame reassembly on the main instance.
  bit          in_frame = 1'b0;
  int          rises = 0, low_cnt = 0, gap_cnt = 0;
  logic        prev_sclk = 1'b0;
  logic [15:0] got = '0;
  exp_t        e;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      in_frame = 1'b0;
      gap_cnt  = 0;
    end else if (!in_frame && nCS === 1'b0) begin
      in_frame  = 1'b1;
      rises     = 0;
      low_cnt   = 1;
      got       = '0;
      prev_sclk = SCLK;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_frame: got frame start, expected none queued");
      end else if (exp_q[0].chk_gap) begin
        check("ncs_gap_cycles", gap_cnt, 4);
      end
    end else if (in_frame && nCS === 1'b0) begin
      low_cnt++;
      if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
        rises++;
        got = {got[14:0], COPI};
      end
      prev_sclk = SCLK;
    end else if (in_frame && nCS === 1'b1) begin
      in_frame = 1'b0;
      gap_cnt  = 1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("frame_word", got, e.word);
        check("sclk_rises", rises, 16);
        check("ncs_low_cycles", low_cnt, 132);
      end
    end else if (!in_frame && nCS === 1'b1) begin
      gap_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, busy, 0);
  endtask

  task automatic wait_idle_w(input int budget, input string name);
    int c = 0;
    while (busy_w !== 1'b0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, busy_w, 0);
  endtask

  task automatic push_w(input int n);
    int   acc = 0;
    int   cyc = 0;
    logic rdy;
    req_valid_w = 1'b1;
    while (acc < n && cyc < n * 60 + 100) begin
      req_addr_w = 7'(acc);
      req_data_w = 8'(acc);
      rdy = req_ready_w;
      @(posedge clk);
      if (rdy) acc++;
      cyc++;
      #1;
    end
    req_valid_w = 1'b0;
    check("wrap_push_count", acc, n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       bp_ready_exp [6];
    logic [15:0] bp_word_exp [5];
    int k, gb, r, lowc;
    logic prev;

    bp_ready_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bp_word_exp  = '{16'h8010, 16'h8111, 16'h8212, 16'h8313, 16'h8414};

    // Reset asserted mid-period from an unreset state.
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_ncs", nCS, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_copi", COPI, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_frames", frames_sent, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single write with latency and gap-to-idle checks.
    exp_q.push_back('{16'h8480, 1'b0});
    req_valid = 1'b1;
    req_addr  = 7'h04;
    req_data  = 8'h80;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("lat_e0_ncs", nCS, 1);
    @(posedge clk);
    #1;
    check("lat_e1_ncs", nCS, 0);
    check("lat_e1_sclk", SCLK, 0);
    check("lat_e1_copi", COPI, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (nCS !== 1'b1 && k < 400);
    check("single_frame_end", nCS, 1);
    gb = 0;
    while (busy === 1'b1 && gb < 20) begin
      gb++;
      @(negedge clk);
    end
    check("gap_busy_cycles", gb, 4);
    check("single_frames_sent", frames_sent, 1);
    check("single_queue_drained", exp_q.size(), 0);

    // Back-to-back requests.
    do_reset();
    exp_q.push_back('{16'h80FF, 1'b0});
    exp_q.push_back('{16'h82A5, 1'b1});
    exp_q.push_back('{16'h810F, 1'b1});
    push(7'h00, 8'hFF);
    push(7'h02, 8'hA5);
    push(7'h01, 8'h0F);
    wait_idle(2000, "b2b_idle");
    check("b2b_frames_sent", frames_sent, 3);
    check("b2b_queue_drained", exp_q.size(), 0);

    // Back-pressure: valid held for 6 cycles from IDLE.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_addr  = 7'(i);
      req_data  = 8'(8'h10 + i);
      check($sformatf("bp_ready_%0d", i), req_ready, bp_ready_exp[i]);
      if (i < 5) exp_q.push_back('{bp_word_exp[i], (i != 0)});
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    k = 5;
    while (req_ready !== 1'b1 && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("bp_ready_release_edge", k, 137);
    wait_idle(4000, "bp_idle");
    check("bp_frames_sent", frames_sent, 5);
    check("bp_queue_drained", exp_q.size(), 0);

    // Reset mid-frame after the 8th SCLK rise with two entries queued.
    do_reset();
    exp_q.push_back('{16'h8311, 1'b0});
    exp_q.push_back('{16'h8422, 1'b1});
    exp_q.push_back('{16'h8533, 1'b1});
    push(7'h03, 8'h11);
    push(7'h04, 8'h22);
    push(7'h05, 8'h33);
    r = 0;
    k = 0;
    prev = 1'b0;
    while (r < 8 && k < 500) begin
      @(negedge clk);
      if (SCLK === 1'b1 && prev === 1'b0) r++;
      prev = SCLK;
      k++;
    end
    check("abort_rises_seen", r, 8);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_ncs", nCS, 1);
    check("abort_sclk", SCLK, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", req_ready, 1);
    check("abort_frames", frames_sent, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lowc = 0;
    repeat (300) begin
      @(negedge clk);
      if (nCS !== 1'b1) lowc++;
    end
    check("abort_no_more_frames", lowc, 0);
    check("abort_busy_after", busy, 0);
    check("abort_frames_after", frames_sent, 0);

    // frames_sent wrap on the fast instance.
    @(negedge clk);
    rst_w = 1'b0;
    @(posedge clk);
    #1;
    check("wrap_rst_frames", frames_sent_w, 0);
    push_w(255);
    wait_idle_w(20000, "wrap_idle_255");
    check("wrap_frames_255", frames_sent_w, 255);
    push_w(1);
    wait_idle_w(200, "wrap_idle_256");
    check("wrap_frames_256", frames_sent_w, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cfg_controller.md
Name: spi_cfg_controller

Overview:
- SPI write-frame sequencer that configures the on-chip SPI register peripheral: output enables 0x00/0x01, PWM enables 0x02/0x03, PWM duty 0x04.
- Accepts (addr, data) write requests over valid/ready and buffers them in a small FIFO.
- Serialises each request as one 16-bit write frame on SCLK/nCS/COPI (mode 0, MSB first).
- Used by on-chip bring-up and test logic to program the peripheral without an external host.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal 1..255.
- FIFO_DEPTH, 4, request FIFO entries; power of two, >=2.
- GAP_CYCLES, 4, clk cycles nCS held high between consecutive frames; legal 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  write request present.
- req_ready  output  1  FIFO can accept; equals !fifo_full.
- req_addr  input  7  register address.
- req_data  input  8  register data.
- busy  output  1  FSM not IDLE or FIFO non-empty.
- SCLK  output  1  SPI clock, idle low.
- nCS  output  1  SPI chip select, active low, idle high.
- COPI  output  1  SPI serial data out.
- frames_sent  output  8  count of completed frames, wraps 255->0.

Behaviour:
- Reset, asynchronous, immediate on any cycle: nCS=1, SCLK=0, COPI=0, FIFO emptied, FSM=IDLE, frames_sent=0, busy=0, req_ready=1. All SPI outputs are registered (no glitches).
- Handshake: push on clk edge where req_valid && req_ready. req_ready is low only when the FIFO is full. Push and pop on the same edge are both legal.
- Frame word: {1'b1, addr[6:0], data[7:0]}. Bit 15 (write flag) is sent first.
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP.
- IDLE: on an edge where the FIFO is non-empty, pop into a 16-bit shift register and a 4-bit bit counter, then go to SETUP.
  - Latency: the request is accepted at edge E0; nCS=0 is driven from edge E0+1.
- SETUP: nCS=0, SCLK=0, COPI=word[15]. Lasts CLK_DIV cycles, then SHIFT_HI.
- SHIFT_HI: SCLK=1 for CLK_DIV cycles. COPI is stable throughout.
  - If bit counter==15, go to HOLD.
  - Otherwise go to SHIFT_LO.
- SHIFT_LO: SCLK=0. COPI updates to the next bit on the entry edge (the SCLK falling edge). Lasts CLK_DIV cycles, increments the bit counter, then returns to SHIFT_HI.
- HOLD: SCLK=0, nCS=0 for CLK_DIV cycles. On exit, nCS=1, frames_sent increments, go to GAP.
- GAP: nCS=1 for GAP_CYCLES cycles, COPI=0.
  - If the FIFO is non-empty, pop and go to SETUP.
  - Otherwise go to IDLE.
- Frame timing:
  - Exactly 16 SCLK rising edges per frame.
  - nCS low for exactly 33*CLK_DIV clk cycles.
  - Minimum nCS-high time between frames is exactly GAP_CYCLES.
- Divider: a single 8-bit down-counter, reloaded with CLK_DIV-1 on every state entry. A state advances when the counter is 0.
- Arithmetic:
  - FIFO pointers are log2(FIFO_DEPTH) bits plus one wrap bit.
  - frames_sent is modulo 256.
  - No address filtering: every accepted request is transmitted, including addresses above 0x04.
- Requests pushed during a frame queue behind it; FIFO order is preserved.
- Reset asserted mid-frame aborts the frame: nCS rises with rst, frames_sent is not incremented, queued entries are lost.

Test Plan:
- Reset: assert rst mid-clock-period -> nCS=1, SCLK=0, COPI=0, busy=0, req_ready=1, frames_sent=0 without waiting for a clk edge.
- Single write (CLK_DIV=4): addr=0x04, data=0x80 -> COPI sampled on SCLK rises = 0x8480; 16 rises; nCS low 132 cycles; frames_sent=1; busy=0 after the 4-cycle gap.
- Back-to-back: push (0x00,0xFF), (0x02,0xA5), (0x01,0x0F) in consecutive cycles -> frames 0x80FF, 0x82A5, 0x810F in order; nCS high exactly 4 cycles between frames; frames_sent=3.
- Back-pressure (FIFO_DEPTH=4): hold req_valid high 6 cycles from IDLE -> 5 requests accepted (edges E0..E4); req_ready=0 at E5 and stays 0 until the next pop at GAP exit.
- Reset mid-frame: assert rst after the 8th SCLK rise with 2 entries queued -> nCS=1 immediately; after release no further frames; FIFO empty; frames_sent=0.
- Counter wrap (CLK_DIV=1, GAP_CYCLES=1): 256 frames -> frames_sent reads 255 after the 255th frame and 0 after the 256th.
